reg_writeback_ctrl: RTL and testbench

//  Write-side initiator for the register file's single write port (regwrite/write_reg/write_data).

---
 rtl/reg_writeback_ctrl.sv | 169 ++++++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port initiator: arbitrates single-cycle ALU results against a
// small in-order FIFO of load responses, tracks pending loads, and registers the winner.
module reg_writeback_ctrl #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [4:0]      fifo_rd_r   [DEPTH];
  logic [XLEN-1:0] fifo_data_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [SW-1:0]   starve_r;
  logic [31:0]     busy_r;
  logic            rf_we_r;
  logic [4:0]      rf_waddr_r;
  logic [XLEN-1:0] rf_wdata_r;

  logic            full_s;
  logic            empty_s;
  logic            force_s;
  logic            pop_s;
  logic            alu_win_s;
  logic            push_s;
  logic [4:0]      head_rd_s;
  logic [XLEN-1:0] head_data_s;
  logic [CW-1:0]   count_nxt_s;
  logic [SW-1:0]   starve_nxt_s;
  logic [31:0]     busy_nxt_s;

  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == {CW{1'b0}});
  assign head_rd_s   = fifo_rd_r[rd_ptr_r];
  assign head_data_s = fifo_data_r[rd_ptr_r];
  // ld_ready comes from the registered count only, so a full FIFO never accepts even while popping
  assign push_s      = ld_valid && !full_s && (ld_rd != 5'd0);

  assign ld_ready  = !full_s;
  assign alu_stall = alu_valid && force_s;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign busy      = busy_r;

  // Pick the single winner of the write slot this cycle
  always_comb begin
    force_s   = !empty_s && (starve_r == SW'(STARVE_MAX));
    pop_s     = 1'b0;
    alu_win_s = 1'b0;
    if (force_s) begin
      pop_s = 1'b1;
    end else if (alu_valid) begin
      alu_win_s = 1'b1;
    end else if (!empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next-state values for occupancy, starvation counter and scoreboard
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase

    if (empty_s || pop_s) begin
      starve_nxt_s = {SW{1'b0}};
    end else if (alu_win_s && (starve_r != SW'(STARVE_MAX))) begin
      starve_nxt_s = starve_r + SW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end

    busy_nxt_s = busy_r;
    if (pop_s) begin
      busy_nxt_s = busy_nxt_s & ~(32'd1 << head_rd_s);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    // Applied after the clear so a same-cycle re-issue keeps the register busy
    if (ld_issue && (ld_issue_rd != 5'd0)) begin
      busy_nxt_s = busy_nxt_s | (32'd1 << ld_issue_rd);
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Load-response FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_r[i]   <= 5'd0;
        fifo_data_r[i] <= {XLEN{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_rd_r[wr_ptr_r]   <= ld_rd;
        fifo_data_r[wr_ptr_r] <= ld_data;
        wr_ptr_r              <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Starvation counter and pending-load scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= {SW{1'b0}};
      busy_r   <= 32'd0;
    end else begin
      starve_r <= starve_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  // Output register toward the RF write port; an ALU win on x0 burns the slot silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= {XLEN{1'b0}};
    end else if (pop_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= head_rd_s;
      rf_wdata_r <= head_data_s;
    end else if (alu_win_s && (alu_rd != 5'd0)) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= alu_rd;
      rf_wdata_r <= alu_data;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: a cycle-by-cycle vector table plus a
// hand-written mid-operation reset sequence.
module tb_reg_writeback_ctrl;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int checks;
  int failures;

  reg_writeback_ctrl #(.XLEN(32), .DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        li;
    logic [4:0]  lird;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_stall;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                              input logic li, input logic [4:0] lird,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                              input logic es, input logic er, input logic ew,
                              input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] eb);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat; v.li = li; v.lird = lird;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.e_stall = es; v.e_ready = er; v.e_we = ew; v.e_waddr = ea; v.e_wdata = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic li, input logic [4:0] lird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_issue = li; ld_issue_rd = lird;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    rst_n = 1'b1;

    // T1 ALU pass
    vecs[0]  = mk(1'b1, 5'd5,  32'hA5,   1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd5,  32'hA5,   32'h0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0);
    // T2 load path with scoreboard
    vecs[2]  = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd7, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h80);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd7, 32'h1234,  1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h80);
    vecs[4]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd7,  32'h1234, 32'h0);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0);
    // T3 fill FIFO under ALU traffic, then drain in order; x9 offered while full is dropped
    vecs[6]  = mk(1'b1, 5'd10, 32'h10,   1'b0, 5'd0, 1'b1, 5'd1, 32'h101,   1'b0, 1'b1, 1'b1, 5'd10, 32'h10,   32'h0);
    vecs[7]  = mk(1'b1, 5'd11, 32'h11,   1'b0, 5'd0, 1'b1, 5'd2, 32'h102,   1'b0, 1'b1, 1'b1, 5'd11, 32'h11,   32'h0);
    vecs[8]  = mk(1'b1, 5'd12, 32'h12,   1'b0, 5'd0, 1'b1, 5'd3, 32'h103,   1'b0, 1'b1, 1'b1, 5'd12, 32'h12,   32'h0);
    vecs[9]  = mk(1'b1, 5'd13, 32'h13,   1'b0, 5'd0, 1'b1, 5'd4, 32'h104,   1'b0, 1'b1, 1'b1, 5'd13, 32'h13,   32'h0);
    vecs[10] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd9, 32'h999,   1'b0, 1'b0, 1'b1, 5'd1,  32'h101,  32'h0);
    vecs[11] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd2,  32'h102,  32'h0);
    vecs[12] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd3,  32'h103,  32'h0);
    vecs[13] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd4,  32'h104,  32'h0);
    vecs[14] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0);
    // T4 starvation: three ALU wins, then forced load with alu_stall, then the held ALU result
    vecs[15] = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd6, 1'b1, 5'd6, 32'h66,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h40);
    vecs[16] = mk(1'b1, 5'd20, 32'h200,  1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd20, 32'h200,  32'h40);
    vecs[17] = mk(1'b1, 5'd21, 32'h201,  1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd21, 32'h201,  32'h40);
    vecs[18] = mk(1'b1, 5'd22, 32'h202,  1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd22, 32'h202,  32'h40);
    vecs[19] = mk(1'b1, 5'd23, 32'h203,  1'b1, 5'd6, 1'b0, 5'd0, 32'd0,     1'b1, 1'b1, 1'b1, 5'd6,  32'h66,   32'h40);
    vecs[20] = mk(1'b1, 5'd23, 32'h203,  1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd23, 32'h203,  32'h40);
    vecs[21] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h40);
    // T5 x0 handling
    vecs[22] = mk(1'b1, 5'd0,  32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h40);
    vecs[23] = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 1'b1, 5'd0, 32'hBEEF,  1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h40);
    vecs[24] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h40);
    // simultaneous push and pop
    vecs[25] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd8, 32'h88,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h40);
    vecs[26] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd9, 32'h99,    1'b0, 1'b1, 1'b1, 5'd8,  32'h88,   32'h40);
    vecs[27] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b1, 5'd9,  32'h99,   32'h40);
    vecs[28] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h40);

    // power-on reset
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_we",    {31'd0, rf_we},     32'd0);
    chk("rst_waddr", {27'd0, rf_waddr},  32'd0);
    chk("rst_wdata", rf_wdata,           32'd0);
    chk("rst_busy",  busy,               32'd0);
    chk("rst_ready", {31'd0, ld_ready},  32'd1);
    chk("rst_stall", {31'd0, alu_stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].li, vecs[i].lird,
            vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, alu_stall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_ready", i), {31'd0, ld_ready},  {31'd0, vecs[i].e_ready});
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].e_waddr});
        chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
    end

    // T6 reset mid-operation with three loads queued
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 1'b1, 5'd3, 32'h303);
    @(posedge clk); #1;
    drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 1'b1, 5'd4, 32'h404);
    @(posedge clk); #1;
    drive(1'b1, 5'd11, 32'hB, 1'b0, 5'd0, 1'b1, 5'd5, 32'h505);
    @(posedge clk); #1;
    chk("t6_pre_busy", busy, 32'h48);
    chk("t6_pre_we",   {31'd0, rf_we}, 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_we",    {31'd0, rf_we},    32'd0);
    chk("t6_rst_busy",  busy,              32'd0);
    chk("t6_rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("t6_rst_waddr", {27'd0, rf_waddr}, 32'd0);
    @(posedge clk); @(posedge clk); #4;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_post%0d_we", c), {31'd0, rf_we}, 32'd0);
      chk($sformatf("t6_post%0d_busy", c), busy, 32'd0);
    end
    // fresh load after reset goes straight through
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0C);
    @(posedge clk); #1;
    chk("t6_new_push_we", {31'd0, rf_we}, 32'd0);
    idle();
    @(posedge clk); #1;
    chk("t6_new_we",    {31'd0, rf_we},    32'd1);
    chk("t6_new_waddr", {27'd0, rf_waddr}, 32'd12);
    chk("t6_new_wdata", rf_wdata,          32'hC0C);
    @(posedge clk); #1;
    chk("t6_new_done",  {31'd0, rf_we},    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
